// File: rtl/iobus_irq_ctrl.sv
`default_nettype none
// ============================================================================
// iobus_irq_ctrl : IOBUS-mapped interrupt controller (pending/mask/overflow)
// Rev 1.0
// ============================================================================
module iobus_irq_ctrl #(
  parameter int          NUM_SRC = 4,
  parameter logic [31:0] BASE_AD = 32'h11300000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC,
  input  logic [31:0]        IOBUS_ADDR,
  input  logic [31:0]        IOBUS_OUT,
  input  logic               IOBUS_WR,
  output logic [31:0]        RD_DATA,
  output logic               RD_HIT,
  output logic               INT
);

  localparam logic [31:0] ADDR_PEND = BASE_AD;
  localparam logic [31:0] ADDR_MASK = BASE_AD + 32'h4;
  localparam logic [31:0] ADDR_ACT  = BASE_AD + 32'h8;
  localparam logic [31:0] ADDR_CTRL = BASE_AD + 32'hC;
  localparam logic [31:0] ADDR_OVF  = BASE_AD + 32'h10;

  logic [NUM_SRC-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d, ovf_q, ovf_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               int_q, int_d;

  logic [NUM_SRC-1:0] rise, pend_clr, ovf_clr, pend_act;
  logic               hit_pend, hit_mask, hit_act, hit_ctrl, hit_ovf;
  logic               act_vld;
  logic [3:0]         act_idx;
  logic               unused_wdata;

  assign unused_wdata = ^IOBUS_OUT[31:NUM_SRC];

  assign hit_pend = (IOBUS_ADDR == ADDR_PEND);
  assign hit_mask = (IOBUS_ADDR == ADDR_MASK);
  assign hit_act  = (IOBUS_ADDR == ADDR_ACT);
  assign hit_ctrl = (IOBUS_ADDR == ADDR_CTRL);
  assign hit_ovf  = (IOBUS_ADDR == ADDR_OVF);

  assign rise     = s2_q & ~s3_q;
  assign pend_act = pend_q & mask_q;

  always_comb begin
    s1_d     = SRC;
    s2_d     = s1_q;
    s3_d     = s2_q;
    pend_clr = (IOBUS_WR && hit_pend) ? IOBUS_OUT[NUM_SRC-1:0] : '0;
    ovf_clr  = (IOBUS_WR && hit_ovf)  ? IOBUS_OUT[NUM_SRC-1:0] : '0;
    mask_d   = (IOBUS_WR && hit_mask) ? IOBUS_OUT[NUM_SRC-1:0] : mask_q;
    ctrl_d   = (IOBUS_WR && hit_ctrl) ? IOBUS_OUT[1:0] : ctrl_q;
    // Level mode tracks the synchronized input; edge mode latches with set-over-clear.
    if (ctrl_q[1]) begin
      pend_d = s2_q;
    end else begin
      pend_d = (pend_q & ~pend_clr) | rise;
    end
    ovf_d = (ovf_q & ~ovf_clr) | (rise & pend_q & ~pend_clr);
    int_d = ctrl_q[0] & (|pend_act);
  end

  always_comb begin
    act_vld = 1'b0;
    act_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_act[i]) begin
        act_vld = 1'b1;
        act_idx = 4'(i);
      end
    end
  end

  always_comb begin
    RD_HIT  = 1'b1;
    RD_DATA = 32'd0;
    if (hit_pend) begin
      RD_DATA = {{(32-NUM_SRC){1'b0}}, pend_q};
    end else if (hit_mask) begin
      RD_DATA = {{(32-NUM_SRC){1'b0}}, mask_q};
    end else if (hit_act) begin
      RD_DATA = {act_vld, 27'd0, act_idx};
    end else if (hit_ctrl) begin
      RD_DATA = {30'd0, ctrl_q};
    end else if (hit_ovf) begin
      RD_DATA = {{(32-NUM_SRC){1'b0}}, ovf_q};
    end else begin
      RD_HIT = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      mask_q <= '0;
      ovf_q  <= '0;
      ctrl_q <= 2'd0;
      int_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      ovf_q  <= ovf_d;
      ctrl_q <= ctrl_d;
      int_q  <= int_d;
    end
  end

  assign INT = int_q;

endmodule
`default_nettype wire

// File: tb/tb_iobus_irq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_iobus_irq_ctrl : directed + random bench with reference model
// Rev 1.0
// ============================================================================
module tb_iobus_irq_ctrl;

  localparam logic [31:0] BASE = 32'h11300000;
  localparam logic [31:0] PEND = BASE;
  localparam logic [31:0] MASK = BASE + 32'h4;
  localparam logic [31:0] ACT  = BASE + 32'h8;
  localparam logic [31:0] CTRL = BASE + 32'hC;
  localparam logic [31:0] OVF  = BASE + 32'h10;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  SRC = 4'd0;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        RD_HIT;
  logic        INT;

  int errors = 0;
  int checks = 0;

  // Reference state: h0/h1/h2 hold SRC as seen at the last three edges.
  logic [3:0] m_pend, m_mask, m_ovf, h0, h1, h2;
  logic [1:0] m_ctrl;
  logic       m_int;

  iobus_irq_ctrl #(.NUM_SRC(4), .BASE_AD(BASE)) dut (
    .CLK(CLK), .RST(RST), .SRC(SRC), .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA),
    .RD_HIT(RD_HIT), .INT(INT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_ovf = 0; m_ctrl = 0; m_int = 0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  function automatic logic exp_hit(input logic [31:0] a);
    return (a == PEND) || (a == MASK) || (a == ACT) || (a == CTRL) || (a == OVF);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [3:0] pm;
    pm = m_pend & m_mask;
    if (a == PEND) return {28'd0, m_pend};
    if (a == MASK) return {28'd0, m_mask};
    if (a == CTRL) return {30'd0, m_ctrl};
    if (a == OVF)  return {28'd0, m_ovf};
    if (a == ACT) begin
      for (int i = 0; i < 4; i++) if (pm[i]) return 32'h80000000 | i;
      return 32'd0;
    end
    return 32'd0;
  endfunction

  task automatic model_edge(input logic [3:0] src, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data);
    logic [3:0] rise, clr, oclr, n_pend, n_ovf;
    logic       n_int;
    rise   = h1 & ~h2;
    clr    = (wr && addr == PEND) ? data[3:0] : 4'd0;
    oclr   = (wr && addr == OVF)  ? data[3:0] : 4'd0;
    n_int  = m_ctrl[0] && ((m_pend & m_mask) != 4'd0);
    n_pend = m_ctrl[1] ? h1 : ((m_pend & ~clr) | rise);
    n_ovf  = (m_ovf & ~oclr) | (rise & m_pend & ~clr);
    if (wr && addr == MASK) m_mask = data[3:0];
    if (wr && addr == CTRL) m_ctrl = data[1:0];
    m_pend = n_pend; m_ovf = n_ovf; m_int = n_int;
    h2 = h1; h1 = h0; h0 = src;
  endtask

  task automatic cycle(input logic [3:0] src, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    SRC = src; IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = data;
    @(posedge CLK);
    model_edge(src, wr, addr, data);
    #1;
    IOBUS_WR = 1'b0;
    chk("int", {31'd0, INT}, {31'd0, m_int});
  endtask

  task automatic idle(input int n, input logic [3:0] src);
    repeat (n) cycle(src, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] src);
    cycle(src, 1'b1, addr, data);
  endtask

  task automatic read_chk(input logic [31:0] addr, input string tag);
    IOBUS_WR = 1'b0; IOBUS_ADDR = addr;
    #1;
    chk({tag, "_hit"}, {31'd0, RD_HIT}, {31'd0, exp_hit(addr)});
    chk({tag, "_data"}, RD_DATA, exp_data(addr));
  endtask

  task automatic rd_const(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    IOBUS_WR = 1'b0; IOBUS_ADDR = addr;
    #1;
    chk(tag, RD_DATA, exp);
  endtask

  task automatic check_regs(input string tag);
    read_chk(PEND, {tag, "_pend"});
    read_chk(MASK, {tag, "_mask"});
    read_chk(ACT,  {tag, "_act"});
    read_chk(CTRL, {tag, "_ctrl"});
    read_chk(OVF,  {tag, "_ovf"});
  endtask

  initial begin
    logic [3:0]  rsrc;
    logic [31:0] raddr;
    int          sel;

    model_reset();
    // Asynchronous reset before any clock edge
    #2 RST = 1'b1;
    #1;
    chk("rst_int", {31'd0, INT}, 32'd0);
    check_regs("rst");
    read_chk(BASE + 32'h20, "rst_nohit");
    chk("nohit_const", {31'd0, RD_HIT}, 32'd0);
    RST = 1'b0;

    // Edge path
    wr(MASK, 32'hF, 4'h0);
    wr(CTRL, 32'h1, 4'h0);
    idle(2, 4'h4);
    rd_const(PEND, 32'h0, "edge_pend_early");
    idle(1, 4'h4);
    rd_const(PEND, 32'h4, "edge_pend");
    chk("edge_int_early", {31'd0, INT}, 32'd0);
    idle(1, 4'h4);
    chk("edge_int", {31'd0, INT}, 32'd1);
    rd_const(ACT, 32'h80000002, "edge_act");
    wr(PEND, 32'h4, 4'h4);
    rd_const(PEND, 32'h0, "edge_w1c");
    chk("edge_int_hold", {31'd0, INT}, 32'd1);
    idle(1, 4'h4);
    chk("edge_int_clr", {31'd0, INT}, 32'd0);

    // Priority and mask with GIE off
    wr(CTRL, 32'h0, 4'h0);
    wr(MASK, 32'h8, 4'h0);
    idle(3, 4'h0);
    idle(3, 4'hA);
    rd_const(PEND, 32'hA, "prio_pend");
    rd_const(ACT, 32'h80000003, "prio_act3");
    wr(MASK, 32'hA, 4'hA);
    rd_const(ACT, 32'h80000001, "prio_act1");
    idle(2, 4'hA);
    chk("prio_gie_off", {31'd0, INT}, 32'd0);
    check_regs("prio");

    // Overflow and set/clear collision
    wr(PEND, 32'hF, 4'h0);
    wr(CTRL, 32'h1, 4'h0);
    idle(3, 4'h0);
    idle(3, 4'h1);
    idle(3, 4'h0);
    idle(3, 4'h1);
    rd_const(OVF, 32'h1, "ovf_set");
    wr(OVF, 32'h1, 4'h1);
    rd_const(OVF, 32'h0, "ovf_w1c");
    idle(3, 4'h2);
    idle(3, 4'h0);
    idle(2, 4'h2);
    wr(PEND, 32'h2, 4'h2);
    rd_const(PEND, 32'h3, "coll_pend");
    rd_const(OVF, 32'h0, "coll_ovf");
    check_regs("coll");

    // Level mode
    wr(CTRL, 32'h3, 4'h0);
    wr(MASK, 32'h1, 4'h0);
    idle(4, 4'h1);
    chk("lvl_int", {31'd0, INT}, 32'd1);
    wr(PEND, 32'h1, 4'h1);
    rd_const(PEND, 32'h1, "lvl_w1c_ignored");
    idle(2, 4'h0);
    rd_const(PEND, 32'h1, "lvl_pend_hold");
    idle(1, 4'h0);
    rd_const(PEND, 32'h0, "lvl_pend_drop");
    chk("lvl_int_hold", {31'd0, INT}, 32'd1);
    idle(1, 4'h0);
    chk("lvl_int_drop", {31'd0, INT}, 32'd0);

    // Mid-cycle reset, including a write that must be lost
    idle(4, 4'h1);
    chk("pre_rst_int", {31'd0, INT}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_int", {31'd0, INT}, 32'd0);
    IOBUS_WR = 1'b1; IOBUS_ADDR = MASK; IOBUS_OUT = 32'hF;
    @(posedge CLK);
    #1;
    model_reset();
    RST = 1'b0;
    rd_const(MASK, 32'h0, "rst_wr_lost");
    check_regs("mid_rst");

    // Randomized traffic against the model
    wr(CTRL, 32'h1, 4'h0);
    wr(MASK, 32'hF, 4'h0);
    rsrc = 4'h0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) rsrc = 4'($urandom);
      sel = $urandom_range(0, 6);
      if (sel < 5)       raddr = BASE + 32'(4 * sel);
      else if (sel == 5) raddr = BASE + 32'h14;
      else               raddr = $urandom;
      cycle(rsrc, ($urandom_range(0, 3) == 0), raddr, $urandom);
      read_chk(BASE + 32'(4 * $urandom_range(0, 5)), "rnd_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
